mul_repeated_add: RTL and testbench

- Unsigned multiplier using repeated addition: P = A × B, computed as A added into an accumulator B times.
- Operands arrive serially on one shared data_in bus: A first, then B on the next cycle.
- Contains the datapath (A register, B down-counter, P accumulator, adder, zero detect) and its control FSM in one block.
- Sits as a slow, area-cheap arithmetic unit behind a start/done handshake.

---
 rtl/mul_repeated_add.sv | 84 ++++++++
 tb/tb_mul_repeated_add.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul_repeated_add.sv
// Unsigned multiplier built from repeated addition: P = A * B mod 2^W.
// A and B are loaded serially from data_in and the product is exposed while done=1.
module mul_repeated_add #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] product,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] a_q, b_q, p_q;
  logic         eqz;
  logic         ld_a, ld_b, clr_p, ld_p, dec_b;

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    return x + y;
  endfunction

  assign eqz = (b_q == '0);

  always_comb begin
    state_nxt = IDLE;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    clr_p     = 1'b0;
    ld_p      = 1'b0;
    dec_b     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   state_nxt = start ? LOAD_A : IDLE;
      LOAD_A: begin
        ld_a      = 1'b1;
        state_nxt = LOAD_B;
      end
      LOAD_B: begin
        ld_b      = 1'b1;
        clr_p     = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        ld_p      = !eqz;
        dec_b     = !eqz;
        state_nxt = eqz ? DONE : CALC;
      end
      DONE: begin
        done      = 1'b1;
        // Stay put until start has been seen low, so a held start cannot re-trigger.
        state_nxt = start ? DONE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
    end else begin
      state <= state_nxt;
      if (ld_a) a_q <= data_in;
      if (ld_b) b_q <= data_in;
      else if (dec_b) b_q <= b_q - W'(1);
      if (clr_p) p_q <= '0;
      else if (ld_p) p_q <= add_mod(p_q, a_q);
    end
  end

  assign product = p_q;

endmodule

// File: tb/tb_mul_repeated_add.sv
// Scoreboard bench for mul_repeated_add: expected products queued at start,
// checked when done rises, with per-edge accumulator and latency checks.
module tb_mul_repeated_add;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] product;
  logic         done;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  mul_repeated_add #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .data_in(data_in), .product(product), .done(done)
  );

  always #5 clk = ~clk;

  // Runs one multiplication; start held high throughout when keep_start=1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_start);
    logic [W-1:0] exp_p, got;
    int n;
    exp_q.push_back(W'(a * b));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);                  // edge k: IDLE -> LOAD_A
    @(negedge clk);
    data_in = a;
    if (!keep_start) start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      data_in = (n == 1) ? b : W'($urandom);
      if (n >= 2 && n <= int'(b) + 2) begin
        exp_p = W'(a * W'(n - 2));
        total++;
        if (product !== exp_p || done !== 1'b0) begin
          bad++;
          $display("FAIL calc_step a=%0d b=%0d n=%0d product=%0d done=%b want product=%0d done=0",
                   a, b, n, product, done, exp_p);
        end
      end
    end while (!done && n < int'(b) + 10);
    total++;
    if (n != int'(b) + 3 || done !== 1'b1) begin
      bad++;
      $display("FAIL latency a=%0d b=%0d edges=%0d done=%b want edges=%0d done=1", a, b, n, done, b + 3);
    end
    got = exp_q.pop_front();
    total++;
    if (product !== got) begin
      bad++;
      $display("FAIL product a=%0d b=%0d got=%h want=%h", a, b, product, got);
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL return_idle done=%b want 0", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (product !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state product=%0d done=%b want 0/0", product, done);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    run_op(16'd5, 16'd4, 1'b1);
  endtask

  task automatic test_handshake();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (done !== 1'b1 || product !== 16'd20) begin
        bad++;
        $display("FAIL hold_done cycle=%0d done=%b product=%0d want 1/20", i, done, product);
      end
    end
    drop_start();
    run_op(16'd3, 16'd6, 1'b0);
  endtask

  task automatic test_zero_mult();
    run_op(16'd7, 16'd0, 1'b0);
    run_op(16'd0, 16'd3, 1'b0);
  endtask

  task automatic test_overflow();
    run_op(16'hFFFF, 16'd2, 1'b0);
    run_op(16'h1234, 16'd17, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd9;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd10;
    repeat (4) @(posedge clk);       // LOAD_B edge plus three additions
    @(negedge clk);
    total++;
    if (product !== 16'd27) begin
      bad++;
      $display("FAIL pre_abort product=%0d want 27", product);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (product !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_abort product=%0d done=%b want 0/0", product, done);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op(16'd11, 16'd7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_handshake();
    test_zero_mult();
    test_overflow();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
